pcpi_dispatch: RTL and testbench
================================

Name: pcpi_dispatch

Overview:
- Sits between the picorv32 PCPI port and NUM_SLV PCPI coprocessors, including tinyml_accelerator as slave 0.
- Decodes custom-0 instructions and forwards each one to exactly one slave.
- Holds the CPU in wait while the slave works, then returns a registered result.
- Enforces a response timeout so a hung slave cannot stall the CPU indefinitely.

Parameters:
NUM_SLV, 2, number of downstream coprocessors (1..8)
TIMEOUT, 64, BUSY cycles without slave ready before a forced completion (>=2)
OPCODE, 7'b0001011, instruction opcode field claimed by the dispatcher (custom-0)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
pcpi_valid  in  1  CPU request valid
pcpi_insn  in  32  instruction word
pcpi_rs1  in  32  operand 1
pcpi_rs2  in  32  operand 2
pcpi_wr  out  1  write rd on completion
pcpi_rd  out  32  result to CPU
pcpi_wait  out  1  request claimed, in progress
pcpi_ready  out  1  completion strobe
s_pcpi_valid  out  NUM_SLV  one-hot per-slave request valid
s_pcpi_insn  out  32  broadcast copy of pcpi_insn
s_pcpi_rs1  out  32  broadcast copy of pcpi_rs1
s_pcpi_rs2  out  32  broadcast copy of pcpi_rs2
s_pcpi_wr  in  NUM_SLV  per-slave write flag
s_pcpi_rd  in  32*NUM_SLV  per-slave result; slave i occupies bits [32i+31:32i]
s_pcpi_wait  in  NUM_SLV  per-slave wait (status only, not required)
s_pcpi_ready  in  NUM_SLV  per-slave completion strobe
busy  out  1  FSM not in IDLE
timeout_flag  out  1  sticky: a forced completion has occurred
clr_status  in  1  synchronous clear of timeout_flag

Behaviour:
- Clock and reset: one clock, clk. Reset resetn is asynchronous, active-low.
- Reset values:
  - All outputs 0; FSM in IDLE; timeout counter 0; sel 0.
  - s_pcpi_insn/rs1/rs2 are combinational pass-throughs, so they follow their inputs even during reset.
- Claim condition (IDLE):
  - pcpi_valid && insn[6:0]==OPCODE && idx<NUM_SLV, where idx = insn[27:25].
  - On claim: register sel=idx, go BUSY.
  - If any term is false: stay IDLE, drive no wait. The CPU's own illegal-instruction timeout then traps.
- BUSY:
  - pcpi_wait=1 and s_pcpi_valid[sel]=1; all other s_pcpi_valid bits 0.
  - First BUSY cycle is claim+1, so wait rises one cycle after the claim.
  - Counter increments each BUSY cycle.
  - If s_pcpi_ready[sel]=1: capture s_pcpi_rd[sel] and s_pcpi_wr[sel], go DONE.
  - Else if counter==TIMEOUT-1: load rd=0 and wr=0, set timeout_flag, go DONE.
  - If slave ready and timeout occur in the same cycle, slave ready wins and timeout_flag is not set.
  - s_pcpi_ready from non-selected slaves is ignored.
- DONE (exactly one cycle):
  - pcpi_ready=1; pcpi_wr/pcpi_rd hold the captured values; pcpi_wait=0; all s_pcpi_valid bits 0.
  - Next state is always IDLE.
  - No claim is evaluated in DONE; a back-to-back request is claimed in the following IDLE cycle.
- pcpi_rd and pcpi_wr are registered and hold their value outside DONE. pcpi_ready is high only in DONE.
- Latency:
  - Slave ready at cycle R gives pcpi_ready at R+1.
  - Minimum end-to-end is claim T, ready T+2, with a slave that answers in its first valid cycle.
- Abort: pcpi_valid falling while in BUSY clears s_pcpi_valid and returns to IDLE with no pcpi_ready. The counter resets. timeout_flag is unchanged.
- timeout_flag:
  - Set has priority over clr_status when both occur in the same cycle.
  - clr_status clears the flag only when no set is pending.
- Reset mid-operation: immediate return to reset values; any in-flight slave transaction is dropped.
- Counter: width $clog2(TIMEOUT+1). Counter is 0 in IDLE and DONE; it cannot wrap.

Decomposition:
- Shared package pcpi_pkg holds:
  - OPCODE_CUSTOM0;
  - the FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - the slave-index field position (insn[27:25]);
  - the PCPI data width of 32.
- The response mux is a natural sub-module, pcpi_resp_mux: a parameterised NUM_SLV-to-1 select of {wr, rd, ready} by sel.
- FSM and timeout logic stay in pcpi_dispatch.

Test Plan:
- Slave 0 answers 3 cycles after s_pcpi_valid with rd=0x0000_1234, wr=1 (insn opcode 0x0B, insn[27:25]=0):
  - pcpi_wait is high from claim+1;
  - pcpi_ready pulses for exactly 1 cycle with pcpi_rd=0x1234, pcpi_wr=1;
  - s_pcpi_valid[1] stays 0 throughout.
- insn[27:25]=1, slave 1 returns 0xDEAD_BEEF while slave 0 pulses ready spuriously:
  - only s_pcpi_valid[1] is asserted;
  - the result is 0xDEADBEEF;
  - slave 0's spurious ready has no effect.
- Non-custom opcode 0x33 (or idx=5 with NUM_SLV=2):
  - pcpi_wait, pcpi_ready and all s_pcpi_valid bits stay 0 for 20 cycles;
  - busy=0.
- Selected slave never answers, TIMEOUT=8:
  - pcpi_ready fires 9 cycles after the claim with wr=0, rd=0;
  - timeout_flag=1 and stays set;
  - clr_status then clears the flag; clr_status asserted in the same cycle as a new timeout leaves the flag at 1.
- Back-to-back requests, then reset:
  - second request claimed 1 cycle after DONE and completes correctly;
  - deasserting resetn mid-BUSY drops s_pcpi_valid and pcpi_wait to 0 asynchronously and the FSM restarts in IDLE.

Source files
------------

// File: rtl/pcpi_pkg.sv
// Shared definitions for the PCPI dispatcher: opcode, FSM encoding and
// the position of the slave-index field inside the instruction word.
package pcpi_pkg;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;
  localparam int         XLEN           = 32;
  localparam int         IDX_LSB        = 25;
  localparam int         IDX_MSB        = 27;
  localparam int         IDX_W          = IDX_MSB - IDX_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [IDX_W-1:0] insn_idx(input logic [XLEN-1:0] insn);
    return insn[IDX_MSB:IDX_LSB];
  endfunction

endpackage

// File: rtl/pcpi_resp_mux.sv
// NUM_SLV-to-1 selection of the slave response {wr, rd, ready} by slave index.
// Built as an AND-OR tree so an out-of-range index yields all zeros.
module pcpi_resp_mux
  import pcpi_pkg::*;
#(
  parameter int NUM_SLV = 2
) (
  input  logic [IDX_W-1:0]        sel,
  input  logic [NUM_SLV-1:0]      s_wr,
  input  logic [XLEN*NUM_SLV-1:0] s_rd,
  input  logic [NUM_SLV-1:0]      s_ready,
  output logic                    wr,
  output logic [XLEN-1:0]         rd,
  output logic                    ready
);

  // AND-OR select of the addressed slave's response
  always_comb begin
    wr    = 1'b0;
    rd    = {XLEN{1'b0}};
    ready = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      wr    = wr    | (s_wr[i]    & (sel == IDX_W'(i)));
      ready = ready | (s_ready[i] & (sel == IDX_W'(i)));
      rd    = rd    | (s_rd[XLEN*i +: XLEN] & {XLEN{sel == IDX_W'(i)}});
    end
  end

endmodule

// File: rtl/pcpi_dispatch.sv
// Routes custom-0 PCPI instructions to one of NUM_SLV coprocessors, holds the
// CPU in wait while the slave works and forces completion after TIMEOUT cycles.
module pcpi_dispatch
  import pcpi_pkg::*;
#(
  parameter int         NUM_SLV = 2,
  parameter int         TIMEOUT = 64,
  parameter logic [6:0] OPCODE  = OPCODE_CUSTOM0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    pcpi_valid,
  input  logic [31:0]             pcpi_insn,
  input  logic [31:0]             pcpi_rs1,
  input  logic [31:0]             pcpi_rs2,
  output logic                    pcpi_wr,
  output logic [31:0]             pcpi_rd,
  output logic                    pcpi_wait,
  output logic                    pcpi_ready,
  output logic [NUM_SLV-1:0]      s_pcpi_valid,
  output logic [31:0]             s_pcpi_insn,
  output logic [31:0]             s_pcpi_rs1,
  output logic [31:0]             s_pcpi_rs2,
  input  logic [NUM_SLV-1:0]      s_pcpi_wr,
  input  logic [32*NUM_SLV-1:0]   s_pcpi_rd,
  input  logic [NUM_SLV-1:0]      s_pcpi_wait,
  input  logic [NUM_SLV-1:0]      s_pcpi_ready,
  output logic                    busy,
  output logic                    timeout_flag,
  input  logic                    clr_status
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e           state_r, state_nxt_s;
  logic [IDX_W-1:0] sel_r;
  logic [CNT_W-1:0] count_r;
  logic [XLEN-1:0]  rd_r;
  logic             wr_r;
  logic             flag_r;

  logic [IDX_W-1:0] idx_s;
  logic             claim_s;
  logic             sel_wr_s, sel_ready_s;
  logic [XLEN-1:0]  sel_rd_s;
  logic             cnt_hit_s, capture_s, timeout_set_s;
  logic             unused_s;

  assign s_pcpi_insn = pcpi_insn;
  assign s_pcpi_rs1  = pcpi_rs1;
  assign s_pcpi_rs2  = pcpi_rs2;

  // Slave wait is status only; the dispatcher keys off ready alone.
  assign unused_s = ^s_pcpi_wait;

  assign idx_s   = insn_idx(pcpi_insn);
  assign claim_s = pcpi_valid && (pcpi_insn[6:0] == OPCODE) && (int'(idx_s) < NUM_SLV);

  pcpi_resp_mux #(.NUM_SLV(NUM_SLV)) u_resp_mux (
    .sel     (sel_r),
    .s_wr    (s_pcpi_wr),
    .s_rd    (s_pcpi_rd),
    .s_ready (s_pcpi_ready),
    .wr      (sel_wr_s),
    .rd      (sel_rd_s),
    .ready   (sel_ready_s)
  );

  assign cnt_hit_s     = (count_r == CNT_W'(TIMEOUT - 1));
  assign capture_s     = (state_r == ST_BUSY) && pcpi_valid && sel_ready_s;
  assign timeout_set_s = (state_r == ST_BUSY) && pcpi_valid && !sel_ready_s && cnt_hit_s;

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= ST_IDLE;
    else         state_r <= state_nxt_s;
  end

  // FSM next-state: abort beats slave ready, slave ready beats timeout
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (claim_s) state_nxt_s = ST_BUSY;
        else         state_nxt_s = ST_IDLE;
      end
      ST_BUSY: begin
        if (!pcpi_valid)      state_nxt_s = ST_IDLE;
        else if (sel_ready_s) state_nxt_s = ST_DONE;
        else if (cnt_hit_s)   state_nxt_s = ST_DONE;
        else                  state_nxt_s = ST_BUSY;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from registered state
  always_comb begin
    busy       = (state_r != ST_IDLE);
    pcpi_wait  = (state_r == ST_BUSY);
    pcpi_ready = (state_r == ST_DONE);
    for (int i = 0; i < NUM_SLV; i++) begin
      s_pcpi_valid[i] = (state_r == ST_BUSY) && (sel_r == IDX_W'(i));
    end
  end

  // Slave select, BUSY-cycle counter, captured result and sticky timeout flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel_r   <= {IDX_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      rd_r    <= {XLEN{1'b0}};
      wr_r    <= 1'b0;
      flag_r  <= 1'b0;
    end else begin
      if ((state_r == ST_IDLE) && claim_s) sel_r <= idx_s;

      if ((state_r == ST_BUSY) && (state_nxt_s == ST_BUSY)) count_r <= count_r + CNT_W'(1);
      else                                                  count_r <= {CNT_W{1'b0}};

      if (capture_s) begin
        rd_r <= sel_rd_s;
        wr_r <= sel_wr_s;
      end else if (timeout_set_s) begin
        rd_r <= {XLEN{1'b0}};
        wr_r <= 1'b0;
      end

      if (timeout_set_s)   flag_r <= 1'b1;
      else if (clr_status) flag_r <= 1'b0;
    end
  end

  assign pcpi_rd      = rd_r;
  assign pcpi_wr      = wr_r;
  assign timeout_flag = flag_r;

endmodule

// File: tb/tb_pcpi_dispatch.sv
// Directed, scoreboard-based bench for pcpi_dispatch (NUM_SLV=2, TIMEOUT=8).
module tb_pcpi_dispatch;

  localparam int NS = 2;
  localparam int TO = 8;

  typedef struct packed {
    logic [31:0] rd;
    logic        wr;
  } resp_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          pcpi_valid;
  logic [31:0]   pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic          pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0]   pcpi_rd;
  logic [NS-1:0] s_pcpi_valid;
  logic [31:0]   s_pcpi_insn, s_pcpi_rs1, s_pcpi_rs2;
  logic [NS-1:0] s_pcpi_wr, s_pcpi_wait, s_pcpi_ready;
  logic [32*NS-1:0] s_pcpi_rd;
  logic          busy, timeout_flag, clr_status;

  int checks = 0;
  int failures = 0;
  resp_t sb[$];

  pcpi_dispatch #(.NUM_SLV(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .s_pcpi_valid(s_pcpi_valid), .s_pcpi_insn(s_pcpi_insn), .s_pcpi_rs1(s_pcpi_rs1),
    .s_pcpi_rs2(s_pcpi_rs2), .s_pcpi_wr(s_pcpi_wr), .s_pcpi_rd(s_pcpi_rd),
    .s_pcpi_wait(s_pcpi_wait), .s_pcpi_ready(s_pcpi_ready),
    .busy(busy), .timeout_flag(timeout_flag), .clr_status(clr_status)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_insn(input logic [6:0] op, input logic [2:0] idx);
    return {4'b0000, idx, 18'h00000, op};
  endfunction

  task automatic issue(input logic [31:0] insn);
    pcpi_valid = 1'b1;
    pcpi_insn  = insn;
    pcpi_rs1   = $urandom;
    pcpi_rs2   = $urandom;
  endtask

  task automatic slave_resp(input int s, input logic rdy, input logic wr, input logic [31:0] rd);
    s_pcpi_ready[s]        = rdy;
    s_pcpi_wr[s]           = wr;
    s_pcpi_rd[32*s +: 32]  = rd;
  endtask

  // Called in the DONE cycle: compare the result against the oldest expectation.
  task automatic check_done(input string tag);
    resp_t e;
    chk({tag, "_ready"}, {31'd0, pcpi_ready}, 32'd1);
    chk({tag, "_wait"},  {31'd0, pcpi_wait},  32'd0);
    chk({tag, "_svalid_done"}, {30'd0, s_pcpi_valid}, 32'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rd"}, pcpi_rd, e.rd);
      chk({tag, "_wr"}, {31'd0, pcpi_wr}, {31'd0, e.wr});
    end
  endtask

  initial begin
    resetn = 1'b0; pcpi_valid = 1'b0; pcpi_insn = 32'h1234_5678;
    pcpi_rs1 = 32'hA5A5_0001; pcpi_rs2 = 32'h5A5A_0002; clr_status = 1'b0;
    s_pcpi_wr = '0; s_pcpi_rd = '0; s_pcpi_wait = '0; s_pcpi_ready = '0;
    #3;
    // reset state and pass-through during reset
    chk("rst_outs", {26'd0, busy, timeout_flag, pcpi_wait, pcpi_ready, s_pcpi_valid}, 32'd0);
    chk("rst_rd", pcpi_rd, 32'd0);
    chk("rst_wr", {31'd0, pcpi_wr}, 32'd0);
    chk("rst_insn_pass", s_pcpi_insn, 32'h1234_5678);
    chk("rst_rs1_pass", s_pcpi_rs1, 32'hA5A5_0001);
    repeat (2) tick();
    resetn = 1'b1;
    tick();

    // 1: slave 0 answers 3 cycles after its valid rises
    issue(mk_insn(7'h0B, 3'd0));
    sb.push_back('{rd: 32'h0000_1234, wr: 1'b1});
    chk("t1_claim_wait", {31'd0, pcpi_wait}, 32'd0);
    chk("t1_rs2_pass", s_pcpi_rs2, pcpi_rs2);
    tick();
    chk("t1_wait_c1", {31'd0, pcpi_wait}, 32'd1);
    chk("t1_svalid", {30'd0, s_pcpi_valid}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("t1_no_ready", {31'd0, pcpi_ready}, 32'd0);
      chk("t1_sv1_low", {31'd0, s_pcpi_valid[1]}, 32'd0);
      if (i == 2) slave_resp(0, 1'b1, 1'b1, 32'h0000_1234);
      tick();
    end
    check_done("t1");
    slave_resp(0, 1'b0, 1'b0, 32'h0);
    pcpi_valid = 1'b0;
    tick();
    chk("t1_ready_1cyc", {31'd0, pcpi_ready}, 32'd0);
    chk("t1_rd_hold", pcpi_rd, 32'h0000_1234);

    // 2: slave 1 selected, slave 0 pulses ready spuriously
    issue(mk_insn(7'h0B, 3'd1));
    sb.push_back('{rd: 32'hDEAD_BEEF, wr: 1'b1});
    tick();
    chk("t2_svalid", {30'd0, s_pcpi_valid}, 32'd2);
    slave_resp(0, 1'b1, 1'b1, 32'hBAD0_BAD0);
    tick();
    chk("t2_spurious_ready", {31'd0, pcpi_ready}, 32'd0);
    chk("t2_spurious_wait", {31'd0, pcpi_wait}, 32'd1);
    slave_resp(0, 1'b0, 1'b0, 32'h0);
    slave_resp(1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    tick();
    check_done("t2");
    slave_resp(1, 1'b0, 1'b0, 32'h0);
    pcpi_valid = 1'b0;
    tick();

    // 3: unclaimed instructions (wrong opcode, out-of-range index)
    issue(mk_insn(7'h33, 3'd0));
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t3_op33_idle", {28'd0, busy, pcpi_wait, pcpi_ready, |s_pcpi_valid}, 32'd0);
    end
    issue(mk_insn(7'h0B, 3'd5));
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t3_idx5_idle", {28'd0, busy, pcpi_wait, pcpi_ready, |s_pcpi_valid}, 32'd0);
    end
    pcpi_valid = 1'b0;
    tick();

    // 4a: slave never answers -> forced completion 9 cycles after claim
    issue(mk_insn(7'h0B, 3'd1));
    sb.push_back('{rd: 32'h0, wr: 1'b0});
    for (int i = 1; i <= TO + 1; i++) begin
      tick();
      if (i <= TO) chk("t4_pre_timeout_ready", {31'd0, pcpi_ready}, 32'd0);
    end
    check_done("t4a");
    chk("t4a_flag", {31'd0, timeout_flag}, 32'd1);
    pcpi_valid = 1'b0;
    repeat (3) tick();
    chk("t4a_flag_sticky", {31'd0, timeout_flag}, 32'd1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("t4a_flag_clr", {31'd0, timeout_flag}, 32'd0);

    // 4b: clr_status in the very cycle a timeout fires -> set wins
    issue(mk_insn(7'h0B, 3'd0));
    sb.push_back('{rd: 32'h0, wr: 1'b0});
    for (int i = 1; i <= TO + 1; i++) begin
      if (i == TO + 1) clr_status = 1'b1;
      tick();
    end
    clr_status = 1'b0;
    check_done("t4b");
    chk("t4b_set_beats_clr", {31'd0, timeout_flag}, 32'd1);
    pcpi_valid = 1'b0;
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;

    // 4c: slave ready in the last BUSY cycle beats the timeout
    issue(mk_insn(7'h0B, 3'd1));
    sb.push_back('{rd: 32'h0000_55AA, wr: 1'b1});
    for (int i = 1; i <= TO + 1; i++) begin
      if (i == TO + 1) slave_resp(1, 1'b1, 1'b1, 32'h0000_55AA);
      tick();
    end
    check_done("t4c");
    chk("t4c_no_flag", {31'd0, timeout_flag}, 32'd0);
    slave_resp(1, 1'b0, 1'b0, 32'h0);
    pcpi_valid = 1'b0;
    tick();

    // 5: back-to-back, minimum latency first
    issue(mk_insn(7'h0B, 3'd0));
    sb.push_back('{rd: 32'h0000_000A, wr: 1'b1});
    tick();
    slave_resp(0, 1'b1, 1'b1, 32'h0000_000A);
    tick();
    check_done("t5a");
    slave_resp(0, 1'b0, 1'b0, 32'h0);
    issue(mk_insn(7'h0B, 3'd1));
    sb.push_back('{rd: 32'h0000_000B, wr: 1'b0});
    tick();
    chk("t5_idle_after_done", {30'd0, busy, pcpi_wait}, 32'd0);
    tick();
    chk("t5b_claimed_wait", {31'd0, pcpi_wait}, 32'd1);
    chk("t5b_svalid", {30'd0, s_pcpi_valid}, 32'd2);
    slave_resp(1, 1'b1, 1'b0, 32'h0000_000B);
    tick();
    check_done("t5b");
    slave_resp(1, 1'b0, 1'b0, 32'h0);
    pcpi_valid = 1'b0;
    tick();

    // 5c: asynchronous reset in the middle of BUSY
    issue(mk_insn(7'h0B, 3'd1));
    tick();
    tick();
    chk("t5c_busy_pre", {31'd0, pcpi_wait}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("t5c_async_drop", {29'd0, busy, pcpi_wait, |s_pcpi_valid}, 32'd0);
    pcpi_valid = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    chk("t5c_idle", {31'd0, busy}, 32'd0);

    // 5d: restart from IDLE after reset
    issue(mk_insn(7'h0B, 3'd0));
    sb.push_back('{rd: 32'hCAFE_0001, wr: 1'b1});
    tick();
    chk("t5d_svalid", {30'd0, s_pcpi_valid}, 32'd1);
    slave_resp(0, 1'b1, 1'b1, 32'hCAFE_0001);
    tick();
    check_done("t5d");
    slave_resp(0, 1'b0, 1'b0, 32'h0);
    pcpi_valid = 1'b0;
    tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
